pipe_ctrl: RTL and testbench
============================

PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 SHALL have parameter MEM_TIMEOUT, default 255, the maximum number of consecutive data-memory wait cycles (1..255) before an error is raised.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-004 SHALL have ports rs1ReadEnable/rs2ReadEnable (input, 1 bit each) and rs1ReadAddr/rs2ReadAddr (input, 5 bits each): the D-stage source registers.
REQ-005 SHALL have ports rdWriteEnableE (input, 1), rdWriteAddrE (input, 5) and RamReadEnableE (input, 1): the E-stage destination and its load flag.
REQ-006 SHALL have ports rdWriteEnableM/W (input, 1 each) and rdWriteAddrM/W (input, 5 each): the M- and W-stage destinations.
REQ-007 SHALL have port redirectE, input, 1 bit: a branch or jump resolved as taken in E.
REQ-008 SHALL have ports memReqM (input, 1) and memReadyM (input, 1): the M-stage data-memory request and its completion.
REQ-009 SHALL have outputs stallF, stallD, stallE, stallM (1 bit each): hold the register at the output of that stage.
REQ-010 SHALL have outputs flushF, flushD, flushE, flushM (1 bit each): clear the register at the output of that stage, inserting a bubble.
REQ-011 SHALL have outputs fwdRs1Sel and fwdRs2Sel, 2 bits each: 00 regfile, 01 E result, 10 M result, 11 W result.
REQ-012 SHALL have output memErr, 1 bit: sticky data-memory timeout flag.

Function
REQ-013 SHALL derive all stall, flush and forward outputs combinationally from the inputs and the registered state; the only registered values are the FSM state, the wait counter, memErr and the counters under REQ-030.
REQ-014 SHALL set fwdRsNSel to the youngest stage (priority E > M > W) whose write enable is set and whose address equals a nonzero rsNReadAddr with rsNReadEnable set; otherwise 00.
REQ-015 SHALL never forward for address x0; in that case fwdRsNSel = 00.
REQ-016 SHALL define loadUse = RamReadEnableE & rdWriteEnableE & (rdWriteAddrE != 0) & (rdWriteAddrE matches an enabled rs1 or rs2).
REQ-017 SHALL respond to loadUse with stallF = stallD = 1 and flushD = 1 for each cycle it holds, normally exactly one cycle.
REQ-018 SHALL respond to redirectE with flushF = flushD = 1 for one cycle.
REQ-019 SHALL define memStall = memReqM & ~memReadyM; while it holds, stallF, stallD, stallE and stallM = 1 and flushM = 1.
REQ-020 SHALL apply priority ERROR > memStall > redirectE > loadUse. A lower-priority condition asserts none of its flushes while a higher one is active, and is re-evaluated once the higher one releases.
REQ-021 SHALL treat redirectE together with loadUse as redirect only; the load-use bubble is discarded.
REQ-022 SHALL implement FSM states RUN, MEM_WAIT and ERROR.
REQ-023 SHALL make these transitions:
 - RUN to MEM_WAIT on memStall.
 - MEM_WAIT to RUN on memReadyM.
 - MEM_WAIT to ERROR when the wait counter equals MEM_TIMEOUT and memReadyM = 0.
 - ERROR is terminal until rst.
REQ-024 SHALL clear the 8-bit wait counter on entry to MEM_WAIT, increment it once per MEM_WAIT cycle, and saturate it at 255.
REQ-025 SHALL, in ERROR, set memErr = 1, assert all stalls, assert flushM, and deassert all other flushes.
REQ-026 SHALL cause no stall when memReqM and memReadyM are both high in the same cycle; the FSM stays in RUN.

Reset
REQ-027 SHALL, on rst, asynchronously force state = RUN, wait counter = 0 and memErr = 0, and clear all counters under REQ-030.
REQ-028 SHALL, during rst, drive all stall and flush outputs to 0 and fwdRs1Sel = fwdRs2Sel = 00.
REQ-029 SHALL abandon any MEM_WAIT or ERROR on reset asserted mid-operation; the first cycle after rst deasserts is in RUN.

Configuration
REQ-030 SHALL compile in, when PIPE_CTRL_PERF_EN is defined:
 - outputs memStallCnt, loadUseCnt and redirectCnt (32 bits each), each incremented by 1 on every cycle its condition is the active winner under REQ-020;
 - wrap from 0xFFFFFFFF to 0.
REQ-031 SHALL, when PIPE_CTRL_PERF_EN is undefined, have neither these ports nor their counter logic, with all other behaviour unchanged.

Verification
REQ-032 SHALL cover forwarding: rs1=5 in D, rdWriteAddrE=5 with write enabled, M also writing x5 -> fwdRs1Sel=01; repeat with rs1=0 -> 00.
REQ-033 SHALL cover load-use: load to x7 in E, D reads x7 on rs2 -> stallF=stallD=flushD=1 for one cycle; next cycle, with the load in M, fwdRs2Sel=10.
REQ-034 SHALL cover memory wait: memReqM high, memReadyM low for 3 cycles then high -> 3 cycles of all stalls plus flushM, state returns to RUN, memErr=0.
REQ-035 SHALL cover simultaneous events: redirectE and memStall together for 2 cycles, then memReadyM -> no flushF/flushD during the wait; flushF=flushD=1 on the first cycle after release.
REQ-036 SHALL cover timeout: MEM_TIMEOUT=4, memReadyM held low -> ERROR after 4 wait cycles, memErr=1, stalls held; rst mid-ERROR -> memErr=0, state RUN.

Source files
------------

// File: rtl/pipe_ctrl.sv
// ---------------------------------------------------------------------------
// pipe_ctrl -- hazard, forwarding and data-memory wait controller for a
// five-stage in-order pipeline (F, D, E, M, W).
//
// Optional feature macro: PIPE_CTRL_PERF_EN
//   When defined, three 32-bit event counters are added as extra outputs.
//   When undefined, neither those ports nor their logic exist.
//
// Parameters
//   MEM_TIMEOUT      wait-counter value (1..255) at which a MEM_WAIT cycle
//                    that still lacks memReadyM moves the FSM to ERROR
//
// Ports
//   clk, rst                          clock, asynchronous active-high reset
//   rs1/rs2ReadEnable, rs1/rs2ReadAddr  D-stage source operands
//   rdWriteEnableE, rdWriteAddrE      E-stage destination
//   RamReadEnableE                    E-stage instruction is a load
//   rdWriteEnableM/W, rdWriteAddrM/W  M- and W-stage destinations
//   redirectE                         taken branch/jump resolved in E
//   memReqM, memReadyM                M-stage data-memory request/completion
//   stallF/D/E/M                      hold the register after that stage
//   flushF/D/E/M                      bubble the register after that stage
//   fwdRs1Sel, fwdRs2Sel              00 regfile, 01 E, 10 M, 11 W
//   memErr                            sticky data-memory timeout flag
//   memStallCnt, loadUseCnt, redirectCnt  (PIPE_CTRL_PERF_EN only)
//
// Event priority: ERROR > memory wait > redirect > load-use. Only the winner
// drives its stalls/flushes in a given cycle; losers are simply re-evaluated
// on the following cycle from the live inputs.
//
// Timeout timing: the wait counter reads 0 in the first MEM_WAIT cycle and
// counts up by one per MEM_WAIT cycle; the MEM_WAIT cycle in which it reads
// MEM_TIMEOUT with memReadyM still low is the last one before ERROR.
// ---------------------------------------------------------------------------
module pipe_ctrl #(
    parameter int unsigned MEM_TIMEOUT = 255
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rs1ReadEnable,
    input  logic       rs2ReadEnable,
    input  logic [4:0] rs1ReadAddr,
    input  logic [4:0] rs2ReadAddr,
    input  logic       rdWriteEnableE,
    input  logic [4:0] rdWriteAddrE,
    input  logic       RamReadEnableE,
    input  logic       rdWriteEnableM,
    input  logic [4:0] rdWriteAddrM,
    input  logic       rdWriteEnableW,
    input  logic [4:0] rdWriteAddrW,
    input  logic       redirectE,
    input  logic       memReqM,
    input  logic       memReadyM,
    output logic       stallF,
    output logic       stallD,
    output logic       stallE,
    output logic       stallM,
    output logic       flushF,
    output logic       flushD,
    output logic       flushE,
    output logic       flushM,
    output logic [1:0] fwdRs1Sel,
    output logic [1:0] fwdRs2Sel,
    output logic       memErr
`ifdef PIPE_CTRL_PERF_EN
    ,
    output logic [31:0] memStallCnt,
    output logic [31:0] loadUseCnt,
    output logic [31:0] redirectCnt
`endif
);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        ERROR    = 2'd2
    } state_t;

    localparam logic [7:0] TIMEOUT_CNT = 8'(MEM_TIMEOUT);

    state_t     state_reg;
    state_t     state_next;
    logic [7:0] wait_cnt_reg;
    logic [7:0] wait_cnt_next;
    logic       mem_err_reg;

    // ------------------------------------------------------------------
    // Operand forwarding, one identical slice per source register.
    // ------------------------------------------------------------------
    logic [1:0]      rs_en;
    logic [1:0][4:0] rs_addr;
    logic [1:0][1:0] fwd_sel;
    logic [1:0]      rs_hit_e;

    assign rs_en   = {rs2ReadEnable, rs1ReadEnable};
    assign rs_addr = {rs2ReadAddr, rs1ReadAddr};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_fwd
            logic src_live;
            logic hit_m;
            logic hit_w;

            // x0 is hard-wired zero, so it never takes a bypass.
            assign src_live     = rs_en[gi] && (rs_addr[gi] != 5'd0);
            assign rs_hit_e[gi] = src_live && rdWriteEnableE && (rdWriteAddrE == rs_addr[gi]);
            assign hit_m        = src_live && rdWriteEnableM && (rdWriteAddrM == rs_addr[gi]);
            assign hit_w        = src_live && rdWriteEnableW && (rdWriteAddrW == rs_addr[gi]);

            // Youngest producer wins.
            assign fwd_sel[gi] = rst          ? 2'b00 :
                                 rs_hit_e[gi] ? 2'b01 :
                                 hit_m        ? 2'b10 :
                                 hit_w        ? 2'b11 : 2'b00;
        end
    endgenerate

    assign fwdRs1Sel = fwd_sel[0];
    assign fwdRs2Sel = fwd_sel[1];

    // ------------------------------------------------------------------
    // Hazard conditions
    // ------------------------------------------------------------------
    logic load_use;
    logic mem_stall;

    // A hit in E already implies a nonzero, enabled, matching source.
    assign load_use = RamReadEnableE && (|rs_hit_e);

    // Once in MEM_WAIT the request is outstanding, so only ready matters.
    assign mem_stall = ((state_reg == RUN) && memReqM && !memReadyM) ||
                       ((state_reg == MEM_WAIT) && !memReadyM);

    // ------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= RUN;
            wait_cnt_reg <= 8'd0;
            mem_err_reg  <= 1'b0;
        end else begin
            state_reg    <= state_next;
            wait_cnt_reg <= wait_cnt_next;
            mem_err_reg  <= mem_err_reg || (state_next == ERROR);
        end
    end

    // ------------------------------------------------------------------
    // FSM next-state and wait counter
    // ------------------------------------------------------------------
    always_comb begin
        state_next    = state_reg;
        wait_cnt_next = wait_cnt_reg;
        case (state_reg)
            RUN: begin
                if (memReqM && !memReadyM) begin
                    state_next    = MEM_WAIT;
                    wait_cnt_next = 8'd0;
                end
            end
            MEM_WAIT: begin
                if (wait_cnt_reg != 8'hFF) begin
                    wait_cnt_next = wait_cnt_reg + 8'd1;
                end
                if (memReadyM) begin
                    state_next = RUN;
                end else if (wait_cnt_reg == TIMEOUT_CNT) begin
                    state_next = ERROR;
                end
            end
            ERROR: begin
                state_next = ERROR;
            end
            default: begin
                state_next = RUN;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Stall / flush outputs, priority ERROR > mem wait > redirect > load-use
    // ------------------------------------------------------------------
    always_comb begin
        stallF = 1'b0;
        stallD = 1'b0;
        stallE = 1'b0;
        stallM = 1'b0;
        flushF = 1'b0;
        flushD = 1'b0;
        flushE = 1'b0;
        flushM = 1'b0;
        if (!rst) begin
            if (state_reg == ERROR || mem_stall) begin
                // Freeze everything; bubble out of M so W sees no stale op.
                stallF = 1'b1;
                stallD = 1'b1;
                stallE = 1'b1;
                stallM = 1'b1;
                flushM = 1'b1;
            end else if (redirectE) begin
                // A coincident load-use bubble is moot: D is being squashed.
                flushF = 1'b1;
                flushD = 1'b1;
            end else if (load_use) begin
                stallF = 1'b1;
                stallD = 1'b1;
                flushD = 1'b1;
            end
        end
    end

    assign memErr = mem_err_reg;

`ifdef PIPE_CTRL_PERF_EN
    // ------------------------------------------------------------------
    // Event counters: count only the condition that actually won a cycle.
    // ------------------------------------------------------------------
    logic win_mem;
    logic win_redirect;
    logic win_load;

    assign win_mem      = (state_reg != ERROR) && mem_stall;
    assign win_redirect = (state_reg != ERROR) && !mem_stall && redirectE;
    assign win_load     = (state_reg != ERROR) && !mem_stall && !redirectE && load_use;

    logic [31:0] mem_stall_cnt_reg;
    logic [31:0] load_use_cnt_reg;
    logic [31:0] redirect_cnt_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_stall_cnt_reg <= 32'd0;
            load_use_cnt_reg  <= 32'd0;
            redirect_cnt_reg  <= 32'd0;
        end else begin
            // Natural 32-bit wrap from all-ones back to zero.
            if (win_mem)      mem_stall_cnt_reg <= mem_stall_cnt_reg + 32'd1;
            if (win_load)     load_use_cnt_reg  <= load_use_cnt_reg + 32'd1;
            if (win_redirect) redirect_cnt_reg  <= redirect_cnt_reg + 32'd1;
        end
    end

    assign memStallCnt = mem_stall_cnt_reg;
    assign loadUseCnt  = load_use_cnt_reg;
    assign redirectCnt = redirect_cnt_reg;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pipe_ctrl -- self-checking bench for pipe_ctrl (MEM_TIMEOUT = 4).
// A directed prologue pins literal expectations for forwarding, load-use,
// memory wait, combined events, timeout and reset; a randomized phase then
// follows. A behavioural model compares every output on every cycle.
// Inputs change 1 time unit after the rising edge; outputs are sampled on
// the falling edge.
// ---------------------------------------------------------------------------
module tb_pipe_ctrl;

    localparam int TO = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       rs1ReadEnable, rs2ReadEnable;
    logic [4:0] rs1ReadAddr, rs2ReadAddr;
    logic       rdWriteEnableE, RamReadEnableE;
    logic [4:0] rdWriteAddrE;
    logic       rdWriteEnableM, rdWriteEnableW;
    logic [4:0] rdWriteAddrM, rdWriteAddrW;
    logic       redirectE, memReqM, memReadyM;
    logic       stallF, stallD, stallE, stallM;
    logic       flushF, flushD, flushE, flushM;
    logic [1:0] fwdRs1Sel, fwdRs2Sel;
    logic       memErr;
`ifdef PIPE_CTRL_PERF_EN
    logic [31:0] memStallCnt, loadUseCnt, redirectCnt;
`endif

    int vectors     = 0;
    int miscompares = 0;

    pipe_ctrl #(.MEM_TIMEOUT(TO)) dut (
        .clk            (clk),
        .rst            (rst),
        .rs1ReadEnable  (rs1ReadEnable),
        .rs2ReadEnable  (rs2ReadEnable),
        .rs1ReadAddr    (rs1ReadAddr),
        .rs2ReadAddr    (rs2ReadAddr),
        .rdWriteEnableE (rdWriteEnableE),
        .rdWriteAddrE   (rdWriteAddrE),
        .RamReadEnableE (RamReadEnableE),
        .rdWriteEnableM (rdWriteEnableM),
        .rdWriteAddrM   (rdWriteAddrM),
        .rdWriteEnableW (rdWriteEnableW),
        .rdWriteAddrW   (rdWriteAddrW),
        .redirectE      (redirectE),
        .memReqM        (memReqM),
        .memReadyM      (memReadyM),
        .stallF         (stallF),
        .stallD         (stallD),
        .stallE         (stallE),
        .stallM         (stallM),
        .flushF         (flushF),
        .flushD         (flushD),
        .flushE         (flushE),
        .flushM         (flushM),
        .fwdRs1Sel      (fwdRs1Sel),
        .fwdRs2Sel      (fwdRs2Sel),
        .memErr         (memErr)
`ifdef PIPE_CTRL_PERF_EN
        ,
        .memStallCnt    (memStallCnt),
        .loadUseCnt     (loadUseCnt),
        .redirectCnt    (redirectCnt)
`endif
    );

    always #5 clk = ~clk;

    // Packed view: {stall FDEM, flush FDEM, fwd1, fwd2, memErr}
    logic [12:0] dut_vec;
    assign dut_vec = {stallF, stallD, stallE, stallM, flushF, flushD, flushE, flushM,
                      fwdRs1Sel, fwdRs2Sel, memErr};

    function automatic logic [12:0] mk(input logic [3:0] s, input logic [3:0] f,
                                       input logic [1:0] a, input logic [1:0] b,
                                       input logic e);
        return {s, f, a, b, e};
    endfunction

    task automatic check(input string name, input logic [12:0] act, input logic [12:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %b expected %b (stall/flush/fwd1/fwd2/err) at t=%0t",
                     name, act, exp, $time);
        end
    endtask

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Behavioural model
    // ------------------------------------------------------------------
    function automatic logic [1:0] ref_fwd(input logic en, input logic [4:0] a);
        if (!en || a == 5'd0)                       return 2'b00;
        if (rdWriteEnableE && rdWriteAddrE == a)    return 2'b01;
        if (rdWriteEnableM && rdWriteAddrM == a)    return 2'b10;
        if (rdWriteEnableW && rdWriteAddrW == a)    return 2'b11;
        return 2'b00;
    endfunction

    bit m_err     = 1'b0;  // timed out, waiting for reset
    bit m_waiting = 1'b0;  // memory request outstanding past its first cycle
    int m_waited  = 0;     // completed cycles spent waiting after the first
    int unsigned m_cnt_mem = 0, m_cnt_ld = 0, m_cnt_rd = 0;

    initial begin
        logic [12:0] exp;
        logic        mem_hold, ld, w_mem, w_rd, w_ld;
        forever begin
            @(negedge clk);
            w_mem = 1'b0; w_rd = 1'b0; w_ld = 1'b0;
            if (rst) begin
                exp = '0;
            end else begin
                mem_hold = m_waiting ? !memReadyM : (memReqM && !memReadyM);
                ld = RamReadEnableE && rdWriteEnableE && rdWriteAddrE != 5'd0 &&
                     ((rs1ReadEnable && rs1ReadAddr == rdWriteAddrE) ||
                      (rs2ReadEnable && rs2ReadAddr == rdWriteAddrE));
                exp = mk(4'b0000, 4'b0000, ref_fwd(rs1ReadEnable, rs1ReadAddr),
                         ref_fwd(rs2ReadEnable, rs2ReadAddr), m_err);
                if (m_err || mem_hold) begin
                    exp[12:9] = 4'b1111;
                    exp[8:5]  = 4'b0001;
                    w_mem     = !m_err;
                end else if (redirectE) begin
                    exp[8:5] = 4'b1100;
                    w_rd     = 1'b1;
                end else if (ld) begin
                    exp[12:9] = 4'b1100;
                    exp[8:5]  = 4'b0100;
                    w_ld      = 1'b1;
                end
            end
            check("model", dut_vec, exp);
`ifdef PIPE_CTRL_PERF_EN
            check32("memStallCnt", memStallCnt, rst ? 32'd0 : m_cnt_mem);
            check32("loadUseCnt",  loadUseCnt,  rst ? 32'd0 : m_cnt_ld);
            check32("redirectCnt", redirectCnt, rst ? 32'd0 : m_cnt_rd);
`endif
            @(posedge clk);
            if (rst) begin
                m_err = 0; m_waiting = 0; m_waited = 0;
                m_cnt_mem = 0; m_cnt_ld = 0; m_cnt_rd = 0;
            end else begin
                m_cnt_mem += w_mem;
                m_cnt_ld  += w_ld;
                m_cnt_rd  += w_rd;
                if (m_err) begin
                    // terminal
                end else if (m_waiting) begin
                    if (memReadyM)           m_waiting = 0;
                    else if (m_waited == TO) m_err = 1;
                    else                     m_waited = (m_waited < 255) ? m_waited + 1 : 255;
                end else if (memReqM && !memReadyM) begin
                    m_waiting = 1;
                    m_waited  = 0;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    task automatic idle();
        rs1ReadEnable = 0; rs2ReadEnable = 0; rs1ReadAddr = 0; rs2ReadAddr = 0;
        rdWriteEnableE = 0; rdWriteAddrE = 0; RamReadEnableE = 0;
        rdWriteEnableM = 0; rdWriteAddrM = 0; rdWriteEnableW = 0; rdWriteAddrW = 0;
        redirectE = 0; memReqM = 0; memReadyM = 0;
    endtask

    // Check current inputs' outputs against a literal, then advance a cycle.
    task automatic cyc(input string name, input logic [12:0] exp);
        @(negedge clk);
        check(name, dut_vec, exp);
        @(posedge clk);
        #1;
    endtask

    localparam logic [3:0] S_ALL = 4'b1111;
    localparam logic [3:0] F_M   = 4'b0001;

    initial begin
        bit pend;
        rst = 1'b1;
        idle();
        // Reset gating: active hazards must not leak through during rst.
        redirectE = 1; memReqM = 1; rs1ReadEnable = 1; rs1ReadAddr = 5;
        rdWriteEnableE = 1; rdWriteAddrE = 5;
        cyc("reset_outputs", mk(0, 0, 0, 0, 0));
        rst = 1'b0;
        idle();
        cyc("idle_after_reset", mk(0, 0, 0, 0, 0));

        // Forwarding priority and x0
        rs1ReadEnable = 1; rs1ReadAddr = 5;
        rdWriteEnableE = 1; rdWriteAddrE = 5; rdWriteEnableM = 1; rdWriteAddrM = 5;
        cyc("fwd_e_over_m", mk(0, 0, 2'b01, 0, 0));
        rs1ReadAddr = 0; rdWriteAddrE = 0; rdWriteAddrM = 0;
        cyc("fwd_x0", mk(0, 0, 0, 0, 0));
        rs1ReadAddr = 5; rdWriteEnableE = 0; rdWriteAddrM = 5;
        rdWriteEnableW = 1; rdWriteAddrW = 5;
        cyc("fwd_m_over_w", mk(0, 0, 2'b10, 0, 0));
        rdWriteEnableM = 0;
        cyc("fwd_w", mk(0, 0, 2'b11, 0, 0));

        // Load-use on rs2, then forward from M
        idle();
        RamReadEnableE = 1; rdWriteEnableE = 1; rdWriteAddrE = 7;
        rs2ReadEnable = 1; rs2ReadAddr = 7;
        cyc("load_use", mk(4'b1100, 4'b0100, 0, 2'b01, 0));
        RamReadEnableE = 0; rdWriteEnableE = 0;
        rdWriteEnableM = 1; rdWriteAddrM = 7;
        cyc("load_fwd_m", mk(0, 0, 0, 2'b10, 0));
        // Redirect together with load-use: redirect only
        idle();
        RamReadEnableE = 1; rdWriteEnableE = 1; rdWriteAddrE = 7;
        rs2ReadEnable = 1; rs2ReadAddr = 7; redirectE = 1;
        cyc("redirect_over_load", mk(0, 4'b1100, 0, 2'b01, 0));

        // Memory wait: 3 low cycles, release, back in RUN
        idle();
        memReqM = 1;
        for (int i = 0; i < 3; i++) cyc("mem_wait", mk(S_ALL, F_M, 0, 0, 0));
        memReadyM = 1;
        cyc("mem_release", mk(0, 0, 0, 0, 0));
        memReqM = 0; memReadyM = 0;
        cyc("mem_back_run", mk(0, 0, 0, 0, 0));
        // Request and ready together: no stall, stays in RUN
        memReqM = 1; memReadyM = 1;
        cyc("mem_same_cycle", mk(0, 0, 0, 0, 0));
        memReqM = 0; memReadyM = 0;
        cyc("mem_same_cycle_run", mk(0, 0, 0, 0, 0));

        // Redirect during memory wait: flushes deferred to release cycle
        redirectE = 1; memReqM = 1;
        for (int i = 0; i < 2; i++) cyc("redirect_in_wait", mk(S_ALL, F_M, 0, 0, 0));
        memReadyM = 1;
        cyc("redirect_after_wait", mk(0, 4'b1100, 0, 0, 0));
        idle();
        cyc("redirect_done", mk(0, 0, 0, 0, 0));

        // Timeout: one RUN stall cycle + MEM_WAIT with counter 0..TO, then ERROR
        memReqM = 1;
        for (int i = 0; i < TO + 2; i++) cyc("timeout_wait", mk(S_ALL, F_M, 0, 0, 0));
        cyc("timeout_error", mk(S_ALL, F_M, 0, 0, 1));
        memReqM = 0; memReadyM = 1; redirectE = 1;
        cyc("error_sticky", mk(S_ALL, F_M, 0, 0, 1));
        rst = 1;
        cyc("error_reset", mk(0, 0, 0, 0, 0));
        rst = 0; memReadyM = 0;
        cyc("run_after_reset", mk(0, 4'b1100, 0, 0, 0));

        // Randomized phase; memory protocol holds a request until ready.
        pend = 0;
        for (int i = 0; i < 3000; i++) begin
            rst            = ($urandom_range(0, 99) < 2);
            rs1ReadEnable  = $urandom_range(0, 1);
            rs2ReadEnable  = $urandom_range(0, 1);
            rs1ReadAddr    = 5'($urandom_range(0, 7));
            rs2ReadAddr    = 5'($urandom_range(0, 7));
            rdWriteEnableE = $urandom_range(0, 1);
            rdWriteAddrE   = 5'($urandom_range(0, 7));
            RamReadEnableE = $urandom_range(0, 1);
            rdWriteEnableM = $urandom_range(0, 1);
            rdWriteAddrM   = 5'($urandom_range(0, 7));
            rdWriteEnableW = $urandom_range(0, 1);
            rdWriteAddrW   = 5'($urandom_range(0, 7));
            redirectE      = ($urandom_range(0, 99) < 15);
            if (pend) begin
                memReqM   = 1;
                memReadyM = ($urandom_range(0, 99) < 35);
            end else begin
                memReqM   = ($urandom_range(0, 99) < 30);
                memReadyM = $urandom_range(0, 1);
            end
            @(posedge clk);
            pend = memReqM && !memReadyM && !rst;
            #1;
        end

        idle();
        rst = 0;
        @(negedge clk);
        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
